fx2_fifo_streamer: RTL and testbench

Parametrised writer for the CY7C68013A (FX2) synchronous slave-FIFO IN path. It is clocked by the FPGA-generated USB_IFCLK and drives FD, SLWR#, PKTEND# and FIFOADR with registered outputs. It sources each word from one of four modes: counter, walking-one, constant or an external valid/ready stream. The block honours the FX2 full flag and commits short packets with PKTEND# when streaming stops or a flush is requested. It sits between the top level's pattern/data logic and the USB_PB/USB_PD/USB_PA/USB_RDY pins.

---
 rtl/fx2_fifo_streamer.sv | 245 ++++++++++++++++++++++++
 tb/tb_fx2_fifo_streamer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx2_fifo_streamer.sv
// -----------------------------------------------------------------------------
// fx2_fifo_streamer
//
// Writer for the CY7C68013A (FX2) synchronous slave-FIFO IN path. Each word
// comes from one of four sources: an incrementing counter, a walking-one
// pattern, a constant, or an external valid/ready stream. Full packets are
// committed by the FX2 AUTOIN logic. A short packet is committed with a single
// PKTEND# pulse when streaming stops or a flush is requested.
//
// Parameters
//   DATA_W     FD width, 8 or 16 (must match the FX2 WORDWIDE setting)
//   PKT_WORDS  words per full packet
//   FIFO_ADDR  endpoint select driven on FIFOADR
//
// Ports
//   USB_IFCLK    in   interface clock; all logic on its rising edge
//   USB_RESET2   in   asynchronous active-low reset
//   EN           in   stream enable (level)
//   FLUSH        in   one-cycle request to commit a partial packet
//   MODE         in   0 counter, 1 walking-one, 2 CONST_DATA, 3 S_DATA
//   CONST_DATA   in   constant pattern
//   S_DATA       in   external stream data
//   S_VALID      in   external stream valid
//   S_READY      out  external stream ready (combinational)
//   FLAG_FULL_N  in   FX2 programmable-full flag (FLAGB), active low
//   FD           out  FIFO data (registered)
//   FD_OE        out  FD output enable (registered)
//   SLWR_N       out  write strobe (registered)
//   PKTEND_N     out  packet-end strobe (registered)
//   SLRD_N       out  read strobe, tied high
//   SLOE_N       out  FIFO output enable, tied high
//   FIFOADR      out  endpoint address, constant FIFO_ADDR
//   WORD_CNT     out  total words written since reset; wraps
//   BUSY         out  high whenever the state is not IDLE
// -----------------------------------------------------------------------------
module fx2_fifo_streamer #(
    parameter int         DATA_W    = 16,
    parameter int         PKT_WORDS = 256,
    parameter logic [1:0] FIFO_ADDR = 2'b00
) (
    input  logic              USB_IFCLK,
    input  logic              USB_RESET2,
    input  logic              EN,
    input  logic              FLUSH,
    input  logic [1:0]        MODE,
    input  logic [DATA_W-1:0] CONST_DATA,
    input  logic [DATA_W-1:0] S_DATA,
    input  logic              S_VALID,
    output logic              S_READY,
    input  logic              FLAG_FULL_N,
    output logic [DATA_W-1:0] FD,
    output logic              FD_OE,
    output logic              SLWR_N,
    output logic              PKTEND_N,
    output logic              SLRD_N,
    output logic              SLOE_N,
    output logic [1:0]        FIFOADR,
    output logic [31:0]       WORD_CNT,
    output logic              BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [1:0] MODE_CNT    = 2'd0;
    localparam logic [1:0] MODE_WALK   = 2'd1;
    localparam logic [1:0] MODE_CONST  = 2'd2;
    localparam logic [1:0] MODE_STREAM = 2'd3;

    localparam int              PKT_W    = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(PKT_WORDS - 1);

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t              state_q,    state_d;
    logic [1:0]          mode_q,     mode_d;
    logic [DATA_W-1:0]   cnt_q,      cnt_d;
    logic [DATA_W-1:0]   walk_q,     walk_d;
    logic [PKT_W-1:0]    pkt_cnt_q,  pkt_cnt_d;
    logic [DATA_W-1:0]   fd_q,       fd_d;
    logic                fd_oe_q,    fd_oe_d;
    logic                slwr_n_q,   slwr_n_d;
    logic                pktend_n_q, pktend_n_d;
    logic [31:0]         word_cnt_q, word_cnt_d;

    logic                s_ready;
    logic                word_avail;
    logic                write_ok;
    logic                exit_req;
    logic [DATA_W-1:0]   word_sel;

    // -------------------------------------------------------------------------
    // Source selection and write qualification
    // -------------------------------------------------------------------------
    // The stream is only offered a handshake when the word it hands over can
    // be written on the same edge, so an accepted beat is never dropped.
    assign s_ready = (state_q == ST_RUN) && (mode_q == MODE_STREAM) &&
                     EN && !FLUSH && FLAG_FULL_N;

    assign word_avail = (mode_q != MODE_STREAM) || (S_VALID && s_ready);

    // A FLUSH is acted on at the very edge it is sampled, so it always beats a
    // write that would otherwise have issued on that edge.
    assign write_ok = (state_q == ST_RUN) && EN && !FLUSH && FLAG_FULL_N && word_avail;
    assign exit_req = !EN || FLUSH;

    always_comb begin
        word_sel = cnt_q;
        case (mode_q)
            MODE_CNT:    word_sel = cnt_q;
            MODE_WALK:   word_sel = walk_q;
            MODE_CONST:  word_sel = CONST_DATA;
            MODE_STREAM: word_sel = S_DATA;
            default:     word_sel = cnt_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; a missing default here would infer a latch.
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        walk_d     = walk_q;
        pkt_cnt_d  = pkt_cnt_q;
        fd_d       = fd_q;
        fd_oe_d    = fd_oe_q;
        slwr_n_d   = 1'b1;
        pktend_n_d = 1'b1;
        word_cnt_d = word_cnt_q;

        case (state_q)
            ST_IDLE: begin
                fd_oe_d = 1'b0;
                if (EN) begin
                    state_d   = ST_RUN;
                    mode_d    = MODE;
                    cnt_d     = '0;
                    walk_d    = DATA_W'(1);
                    pkt_cnt_d = '0;
                    fd_oe_d   = 1'b1;
                end
            end

            ST_RUN: begin
                if (exit_req) begin
                    if (pkt_cnt_q != '0) begin
                        // Partial packet in the FX2 buffer: commit it.
                        pktend_n_d = 1'b0;
                        state_d    = ST_COMMIT;
                    end else if (!EN) begin
                        state_d = ST_IDLE;
                        fd_oe_d = 1'b0;
                    end
                    // EN still high with an empty packet: the flush has
                    // nothing to commit and is simply dropped.
                end else if (write_ok) begin
                    fd_d       = word_sel;
                    slwr_n_d   = 1'b0;
                    word_cnt_d = word_cnt_q + 32'd1;
                    // Wrapping on the last word leaves the commit to AUTOIN.
                    pkt_cnt_d  = (pkt_cnt_q == PKT_LAST) ? '0 : pkt_cnt_q + PKT_W'(1);
                    if (mode_q == MODE_CNT) begin
                        cnt_d = cnt_q + DATA_W'(1);
                    end
                    if (mode_q == MODE_WALK) begin
                        walk_d = {walk_q[DATA_W-2:0], walk_q[DATA_W-1]};
                    end
                end
            end

            ST_COMMIT: begin
                // PKTEND_N is low for exactly this one cycle; the full flag is
                // not consulted because a commit adds no data to the FIFO.
                pkt_cnt_d = '0;
                if (EN) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                    fd_oe_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                fd_oe_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs, independent of statement order.
    // NOTE: all registers here are control or output state and take a reset
    // value; there is no storage array that could be left unreset.
    always_ff @(posedge USB_IFCLK or negedge USB_RESET2) begin
        if (!USB_RESET2) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_CNT;
            cnt_q      <= '0;
            walk_q     <= DATA_W'(1);
            pkt_cnt_q  <= '0;
            fd_q       <= '0;
            fd_oe_q    <= 1'b0;
            slwr_n_q   <= 1'b1;
            pktend_n_q <= 1'b1;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            walk_q     <= walk_d;
            pkt_cnt_q  <= pkt_cnt_d;
            fd_q       <= fd_d;
            fd_oe_q    <= fd_oe_d;
            slwr_n_q   <= slwr_n_d;
            pktend_n_q <= pktend_n_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign S_READY  = s_ready;
    assign FD       = fd_q;
    assign FD_OE    = fd_oe_q;
    assign SLWR_N   = slwr_n_q;
    assign PKTEND_N = pktend_n_q;
    assign SLRD_N   = 1'b1;
    assign SLOE_N   = 1'b1;
    assign FIFOADR  = FIFO_ADDR;
    assign WORD_CNT = word_cnt_q;
    assign BUSY     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fx2_fifo_streamer.sv
// -----------------------------------------------------------------------------
// tb_fx2_fifo_streamer
//
// Scoreboard bench for fx2_fifo_streamer (DATA_W=8, PKT_WORDS=4). Stimulus
// pushes the word each expected write must carry; a negedge monitor pops and
// compares whenever SLWR_N is low and counts PKTEND_N pulses.
// -----------------------------------------------------------------------------
module tb_fx2_fifo_streamer;

    localparam int         DATA_W    = 8;
    localparam int         PKT_WORDS = 4;
    localparam logic [1:0] FIFO_ADDR = 2'b10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              flush;
    logic [1:0]        mode;
    logic [DATA_W-1:0] const_data;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              flag_full_n;
    logic [DATA_W-1:0] fd;
    logic              fd_oe;
    logic              slwr_n;
    logic              pktend_n;
    logic              slrd_n;
    logic              sloe_n;
    logic [1:0]        fifoadr;
    logic [31:0]       word_cnt;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int pktend_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];

    fx2_fifo_streamer #(
        .DATA_W   (DATA_W),
        .PKT_WORDS(PKT_WORDS),
        .FIFO_ADDR(FIFO_ADDR)
    ) u_dut (
        .USB_IFCLK  (clk),
        .USB_RESET2 (rst_n),
        .EN         (en),
        .FLUSH      (flush),
        .MODE       (mode),
        .CONST_DATA (const_data),
        .S_DATA     (s_data),
        .S_VALID    (s_valid),
        .S_READY    (s_ready),
        .FLAG_FULL_N(flag_full_n),
        .FD         (fd),
        .FD_OE      (fd_oe),
        .SLWR_N     (slwr_n),
        .PKTEND_N   (pktend_n),
        .SLRD_N     (slrd_n),
        .SLOE_N     (sloe_n),
        .FIFOADR    (fifoadr),
        .WORD_CNT   (word_cnt),
        .BUSY       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every write against the scoreboard and counts commits.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!slwr_n) begin
                check("write expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [DATA_W-1:0] exp_w;
                    exp_w = exp_q.pop_front();
                    check("fd word", 32'(fd), 32'(exp_w));
                end
            end
            if (!pktend_n) begin
                pktend_cnt++;
                check("pktend without write", 32'(slwr_n), 32'd1);
                check("pktend with fd_oe", 32'(fd_oe), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int base_cnt;
        logic acc_now;
        logic exp_rdy;

        rst_n       = 1'b0;
        en          = 1'b0;
        flush       = 1'b0;
        mode        = 2'd0;
        const_data  = 8'h00;
        s_data      = 8'h00;
        s_valid     = 1'b0;
        flag_full_n = 1'b1;

        // ---------------- Reset values ----------------
        repeat (3) tick();
        check("rst fd", 32'(fd), 32'd0);
        check("rst fd_oe", 32'(fd_oe), 32'd0);
        check("rst slwr_n", 32'(slwr_n), 32'd1);
        check("rst pktend_n", 32'(pktend_n), 32'd1);
        check("rst slrd_n", 32'(slrd_n), 32'd1);
        check("rst sloe_n", 32'(sloe_n), 32'd1);
        check("rst fifoadr", 32'(fifoadr), 32'(FIFO_ADDR));
        check("rst word_cnt", word_cnt, 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst s_ready", 32'(s_ready), 32'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- Mode 0: counter 0..9 ----------------
        pktend_cnt = 0;
        mode = 2'd0;
        en   = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back(8'(i));
        tick();
        check("run entry busy", 32'(busy), 32'd1);
        check("run entry fd_oe", 32'(fd_oe), 32'd1);
        check("run entry no write", 32'(slwr_n), 32'd1);
        tick();
        check("first write latency", 32'(slwr_n), 32'd0);
        repeat (9) tick();
        check("mode0 word_cnt", word_cnt, 32'd10);
        en = 1'b0;
        tick();
        check("mode0 commit pktend", 32'(pktend_n), 32'd0);
        tick();
        check("mode0 idle busy", 32'(busy), 32'd0);
        check("mode0 idle fd_oe", 32'(fd_oe), 32'd0);
        check("mode0 pktend count", pktend_cnt, 32'd1);
        check("mode0 queue drained", exp_q.size(), 32'd0);

        // ---------------- Mode 1: walking one, MODE change mid-run ----------------
        mode = 2'd1;
        en   = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back(8'h01 << (i % 8));
        tick();
        repeat (3) tick();
        mode = 2'd0;
        repeat (7) tick();
        en = 1'b0;
        repeat (2) tick();
        check("mode1 word_cnt", word_cnt, 32'd20);
        check("mode1 queue drained", exp_q.size(), 32'd0);

        // ---------------- Full flag gap, FLUSH, EN+FLUSH ----------------
        pktend_cnt = 0;
        mode = 2'd0;
        en   = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
        tick();
        repeat (3) tick();
        flag_full_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("full no write", 32'(slwr_n), 32'd1);
        end
        flag_full_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("resume write", 32'(slwr_n), 32'd0);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush beats write", 32'(slwr_n), 32'd1);
        check("flush pktend", 32'(pktend_n), 32'd0);
        tick();
        check("commit to run busy", 32'(busy), 32'd1);
        check("commit to run pktend", 32'(pktend_n), 32'd1);
        check("commit to run fd_oe", 32'(fd_oe), 32'd1);
        repeat (2) tick();
        en    = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("en+flush pktend", 32'(pktend_n), 32'd0);
        tick();
        check("en+flush idle", 32'(busy), 32'd0);
        check("flag phase pktend count", pktend_cnt, 32'd2);
        check("flag phase word_cnt", word_cnt, 32'd28);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("idle flush ignored busy", 32'(busy), 32'd0);
        check("idle flush ignored pktend", 32'(pktend_n), 32'd1);
        check("flag phase queue drained", exp_q.size(), 32'd0);

        // ---------------- Packet boundary: 6 words, then exactly 4 ----------------
        pktend_cnt = 0;
        mode = 2'd0;
        en   = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(8'(i));
        tick();
        repeat (4) tick();
        check("no pktend at boundary", 32'(pktend_n), 32'd1);
        repeat (2) tick();
        en = 1'b0;
        tick();
        check("short pkt pktend", 32'(pktend_n), 32'd0);
        tick();
        check("short pkt idle fd_oe", 32'(fd_oe), 32'd0);
        check("short pkt pktend count", pktend_cnt, 32'd1);

        pktend_cnt = 0;
        mode       = 2'd2;
        const_data = 8'h5A;
        en         = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h5A);
        tick();
        repeat (4) tick();
        en = 1'b0;
        tick();
        check("wrap exit busy", 32'(busy), 32'd0);
        check("wrap exit fd_oe", 32'(fd_oe), 32'd0);
        check("wrap exit pktend", 32'(pktend_n), 32'd1);
        tick();
        check("wrap exit pktend count", pktend_cnt, 32'd0);
        check("boundary word_cnt", word_cnt, 32'd38);
        check("boundary queue drained", exp_q.size(), 32'd0);

        // ---------------- Mode 3: external stream ----------------
        pktend_cnt = 0;
        base_cnt   = 38;
        acc        = 0;
        mode       = 2'd3;
        en         = 1'b1;
        tick();
        for (int k = 0; k < 20; k++) begin
            s_valid     = 1'($urandom_range(0, 1));
            s_data      = 8'(8'hC0 + k);
            flag_full_n = !(k >= 8 && k < 11);
            #1;
            exp_rdy = flag_full_n;
            check("s_ready", 32'(s_ready), 32'(exp_rdy));
            acc_now = s_valid && exp_rdy;
            if (acc_now) begin
                exp_q.push_back(s_data);
                acc++;
            end
            tick();
            check("stream write slot", 32'(slwr_n), 32'(!acc_now));
        end
        flag_full_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (acc % PKT_WORDS != 0) begin
                s_valid = 1'b1;
                s_data  = 8'(8'hE0 + k);
                exp_q.push_back(s_data);
                acc++;
                tick();
            end
        end
        s_valid = 1'b0;
        flush   = 1'b1;
        tick();
        flush = 1'b0;
        check("empty flush no pktend", 32'(pktend_n), 32'd1);
        check("empty flush stays run", 32'(busy), 32'd1);
        check("empty flush no write", 32'(slwr_n), 32'd1);
        tick();
        en = 1'b0;
        tick();
        check("stream idle busy", 32'(busy), 32'd0);
        check("stream idle s_ready", 32'(s_ready), 32'd0);
        check("stream pktend count", pktend_cnt, 32'd0);
        check("stream word_cnt", word_cnt, 32'(base_cnt + acc));
        check("stream queue drained", exp_q.size(), 32'd0);

        // ---------------- Asynchronous reset mid-packet ----------------
        pktend_cnt = 0;
        mode = 2'd0;
        en   = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(8'(i));
        tick();
        repeat (3) tick();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst fd", 32'(fd), 32'd0);
        check("async rst slwr_n", 32'(slwr_n), 32'd1);
        check("async rst fd_oe", 32'(fd_oe), 32'd0);
        check("async rst pktend_n", 32'(pktend_n), 32'd1);
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst word_cnt", word_cnt, 32'd0);
        check("async rst s_ready", 32'(s_ready), 32'd0);
        en = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post rst pktend count", pktend_cnt, 32'd0);
        check("post rst busy", 32'(busy), 32'd0);
        check("final queue drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
